// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit data memory: RV32I funct3
// encodings, the response FSM state type and the byte-enable helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } lsu_state_e;

  // Byte-lane write enables for a store of the given size at the given lane.
  // Lane must already be aligned to the access size; non-store encodings give 0.
  function automatic logic [3:0] byte_enables(input logic [2:0] funct3,
                                              input logic [1:0] lane);
    logic [3:0] be;
    case (funct3)
      F3_B:    be = 4'b0001 << lane;
      F3_H:    be = 4'b0011 << lane;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load data extraction: picks the addressed byte/halfword out
// of a raw memory word and sign- or zero-extends it to 32 bits.
// Kept separate so a future cache read path can share it.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] raw_word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the lane and apply RV32I extension; unknown encodings return 0.
  always_comb begin
    byte_sel = raw_word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? raw_word[31:16] : raw_word[15:0];
    case (funct3)
      F3_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ext_data = {24'h000000, byte_sel};
      F3_H:    ext_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ext_data = {16'h0000, half_sel};
      F3_W:    ext_data = raw_word;
      default: ext_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_data_mem.sv
// Data memory for the RISC-V datapath. One load or store per cycle over a
// valid/ready request channel, registered response with error flag.
// Byte/halfword/word accesses with per-byte write lanes.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word accesses fault; otherwise they are silently aligned down.
module lsu_data_mem
  import lsu_pkg::*;
#(
  parameter int                 DEPTH_WORDS = 256,
  parameter int                 ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [2:0]        REQ_FUNCT3,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [31:0]       RSP_RDATA,
  output logic              RSP_ERR
);

  localparam int              IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] SPAN  = (ADDR_W + 1)'(4 * DEPTH_WORDS);

  // Request decode
  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic              f3_legal;
  logic              misalign;
  logic              req_err;
  logic [1:0]        lane_raw;
  logic [1:0]        lane_eff;
  logic [IDX_W-1:0]  word_idx;
  logic [3:0]        wr_be;
  logic [31:0]       wdata_rep;
  logic              accept;
  logic              wr_en;
  logic              rd_en;

  // FSM and response payload
  lsu_state_e state_q, state_d;
  logic       err_q, err_d;
  logic       is_load_q, is_load_d;
  logic [1:0] lane_q, lane_d;
  logic [2:0] f3_q, f3_d;
  logic       rsp_valid;

  logic [31:0] rd_word;
  logic [31:0] ext_data;

  // Decode address, size and legality of the presented request.
  always_comb begin
    offset    = REQ_ADDR - BASE_ADDR;
    in_range  = ({1'b0, offset} < SPAN);
    word_idx  = offset[IDX_W+1:2];
    lane_raw  = offset[1:0];
    f3_legal  = 1'b0;
    lane_eff  = lane_raw;
    misalign  = 1'b0;
    wdata_rep = REQ_WDATA;

    if (REQ_WE) begin
      f3_legal = (REQ_FUNCT3 == F3_B) || (REQ_FUNCT3 == F3_H) || (REQ_FUNCT3 == F3_W);
    end else begin
      f3_legal = (REQ_FUNCT3 == F3_B)  || (REQ_FUNCT3 == F3_H) || (REQ_FUNCT3 == F3_W) ||
                 (REQ_FUNCT3 == F3_BU) || (REQ_FUNCT3 == F3_HU);
    end

    case (REQ_FUNCT3)
      F3_H, F3_HU: lane_eff = {lane_raw[1], 1'b0};
      F3_W:        lane_eff = 2'b00;
      default:     lane_eff = lane_raw;
    endcase

`ifdef LSU_MISALIGN_TRAP_EN
    case (REQ_FUNCT3)
      F3_H, F3_HU: misalign = lane_raw[0];
      F3_W:        misalign = (lane_raw != 2'b00);
      default:     misalign = 1'b0;
    endcase
`else
    misalign = 1'b0;
`endif

    case (REQ_FUNCT3)
      F3_B:    wdata_rep = {4{REQ_WDATA[7:0]}};
      F3_H:    wdata_rep = {2{REQ_WDATA[15:0]}};
      default: wdata_rep = REQ_WDATA;
    endcase

    req_err = !in_range || !f3_legal || misalign;
    wr_be   = byte_enables(REQ_FUNCT3, lane_eff);
    accept  = REQ_VALID && REQ_READY;
    // A store coinciding with reset must not reach the array.
    wr_en   = accept && REQ_WE && !req_err && !RST;
    rd_en   = accept && !REQ_WE;
  end

  // One byte-wide array per lane so each lane maps onto its own RAM column.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH_WORDS];
      logic [7:0] rd_byte_q;

      // Byte-lane write and registered read; contents are never reset.
      always_ff @(posedge CLK) begin
        if (wr_en && wr_be[gi]) begin
          mem_lane[word_idx] <= wdata_rep[gi*8 +: 8];
        end
        if (rd_en) begin
          rd_byte_q <= mem_lane[word_idx];
        end
      end

      assign rd_word[gi*8 +: 8] = rd_byte_q;
    end
  endgenerate

  lsu_load_extend u_load_extend (
    .raw_word (rd_word),
    .lane     (lane_q),
    .funct3   (f3_q),
    .ext_data (ext_data)
  );

  // State and response payload registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      err_q     <= 1'b0;
      is_load_q <= 1'b0;
      lane_q    <= 2'b00;
      f3_q      <= 3'b000;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      is_load_q <= is_load_d;
      lane_q    <= lane_d;
      f3_q      <= f3_d;
    end
  end

  // Next state: a response is pending from accept until it is consumed
  // without a replacement being accepted on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RESP;
      RESP:    if (RSP_READY && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture response attributes on accept, hold them otherwise.
  always_comb begin
    err_d     = err_q;
    is_load_d = is_load_q;
    lane_d    = lane_q;
    f3_d      = f3_q;
    if (accept) begin
      err_d     = req_err;
      is_load_d = !REQ_WE;
      lane_d    = lane_eff;
      f3_d      = REQ_FUNCT3;
    end
  end

  // Outputs derive only from registered state, never from REQ_* directly.
  always_comb begin
    rsp_valid = (state_q == RESP);
    RSP_VALID = rsp_valid;
    REQ_READY = !rsp_valid || RSP_READY;
    RSP_ERR   = rsp_valid && err_q;
    RSP_RDATA = (rsp_valid && is_load_q && !err_q) ? ext_data : 32'h0000_0000;
  end

endmodule

// File: tb/tb_lsu_data_mem.sv
// Self-checking bench for lsu_data_mem: scoreboard queue of expected
// responses, one task per scenario, one line printed per response.
module tb_lsu_data_mem;
  import lsu_pkg::*;

  localparam int DEPTH = 256;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        REQ_WE = 1'b0;
  logic [2:0]  REQ_FUNCT3 = 3'b000;
  logic [31:0] REQ_ADDR = 32'h0;
  logic [31:0] REQ_WDATA = 32'h0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b1;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] model_mem [8];

  lsu_data_mem #(
    .DEPTH_WORDS (DEPTH),
    .ADDR_W      (32),
    .BASE_ADDR   (32'h0)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_WE     (REQ_WE),
    .REQ_FUNCT3 (REQ_FUNCT3),
    .REQ_ADDR   (REQ_ADDR),
    .REQ_WDATA  (REQ_WDATA),
    .RSP_VALID  (RSP_VALID),
    .RSP_READY  (RSP_READY),
    .RSP_RDATA  (RSP_RDATA),
    .RSP_ERR    (RSP_ERR)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: compare every handshaken response against the queue head.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && RSP_VALID && RSP_READY) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_rsp: got rdata=%h err=%b, required no response", RSP_RDATA, RSP_ERR);
      end else begin
        e = exp_q.pop_front();
        if (RSP_RDATA !== e.rdata || RSP_ERR !== e.err) begin
          tests_failed++;
          $display("FAIL %s: got rdata=%h err=%b, required rdata=%h err=%b",
                   e.name, RSP_RDATA, RSP_ERR, e.rdata, e.err);
        end else begin
          $display("[TB] rsp %s rdata=%h err=%b", e.name, RSP_RDATA, RSP_ERR);
        end
      end
    end
  end

  // Present one request, push its expected response, return 1ns after the accept edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input logic exp_err, input string name);
    int waited = 0;
    REQ_VALID  = 1'b1;
    REQ_WE     = we;
    REQ_FUNCT3 = f3;
    REQ_ADDR   = addr;
    REQ_WDATA  = wdata;
    #0;
    while (!REQ_READY && waited < 50) begin
      @(posedge CLK);
      #1;
      waited++;
    end
    if (!REQ_READY) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_accept_timeout: ready=%b after %0d cycles, required 1", name, REQ_READY, waited);
    end
    exp_q.push_back('{exp_rd, exp_err, name});
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
  endtask

  // Wait (bounded) for all expected responses to be consumed.
  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d responses outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = (lane >= 2'd2) ? w[31:16] : w[15:0];
    case (f3)
      3'b000: return {{24{b[7]}}, b};
      3'b100: return {24'h0, b};
      3'b001: return {{16{h[15]}}, h};
      3'b101: return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] lane, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (f3)
      3'b000: case (lane)
                2'd0: r[7:0]   = d[7:0];
                2'd1: r[15:8]  = d[7:0];
                2'd2: r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
              endcase
      3'b001: if (lane[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic test_reset;
    #2 RST = 1'b1;
    #1;
    tests_run++;
    if (RSP_VALID !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b, required 0", RSP_VALID); end
    tests_run++;
    if (RSP_ERR !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_err: got %b, required 0", RSP_ERR); end
    tests_run++;
    if (RSP_RDATA !== 32'h0) begin tests_failed++; $display("FAIL reset_rsp_rdata: got %h, required 0", RSP_RDATA); end
    tests_run++;
    if (REQ_READY !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready: got %b, required 1", REQ_READY); end
    @(posedge CLK);
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic test_store_load;
    issue(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw_10");
    issue(1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10");
    tests_run++;
    if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL lw_latency: got valid=%b rdata=%h one cycle after accept, required valid=1 rdata=deadbeef",
               RSP_VALID, RSP_RDATA);
    end
    drain("store_load");
  endtask

  task automatic test_extend;
    issue(1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, "lb_13");
    issue(1'b0, F3_BU, 32'h13, 32'h0, 32'h000000DE, 1'b0, "lbu_13");
    issue(1'b0, F3_H,  32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, "lh_12");
    issue(1'b0, F3_HU, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, "lhu_10");
    issue(1'b0, F3_B,  32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, "lb_10");
    issue(1'b0, F3_H,  32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, "lh_10");
    issue(1'b0, F3_BU, 32'h11, 32'h0, 32'h000000BE, 1'b0, "lbu_11");
    drain("extend");
  endtask

  task automatic test_byte_store;
    issue(1'b1, F3_B,  32'h11, 32'hAAAAAA55, 32'h0, 1'b0, "sb_11");
    issue(1'b0, F3_W,  32'h10, 32'h0, 32'hDEAD55EF, 1'b0, "lw_10_after_sb");
    issue(1'b1, F3_W,  32'h14, 32'h00000000, 32'h0, 1'b0, "sw_14_zero");
    issue(1'b1, F3_H,  32'h16, 32'hFFFFCAFE, 32'h0, 1'b0, "sh_16");
    issue(1'b0, F3_W,  32'h14, 32'h0, 32'hCAFE0000, 1'b0, "lw_14_after_sh");
    issue(1'b0, F3_HU, 32'h16, 32'h0, 32'h0000CAFE, 1'b0, "lhu_16");
    issue(1'b0, F3_B,  32'h17, 32'h0, 32'hFFFFFFCA, 1'b0, "lb_17");
    drain("byte_store");
  endtask

  task automatic test_misalign;
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b0, F3_W, 32'h12, 32'h0, 32'h0, 1'b1, "lw_12_trap");
    issue(1'b0, F3_H, 32'h11, 32'h0, 32'h0, 1'b1, "lh_11_trap");
    issue(1'b1, F3_W, 32'h12, 32'h11111111, 32'h0, 1'b1, "sw_12_trap");
    issue(1'b0, F3_W, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, "lw_10_after_trap");
`else
    issue(1'b0, F3_W,  32'h12, 32'h0, 32'hDEAD55EF, 1'b0, "lw_12_align");
    issue(1'b0, F3_H,  32'h11, 32'h0, 32'h000055EF, 1'b0, "lh_11_align");
    issue(1'b0, F3_HU, 32'h13, 32'h0, 32'h0000DEAD, 1'b0, "lhu_13_align");
    issue(1'b1, F3_W,  32'h12, 32'h11111111, 32'h0, 1'b0, "sw_12_align");
    issue(1'b0, F3_W,  32'h10, 32'h0, 32'h11111111, 1'b0, "lw_10_after_align");
    issue(1'b1, F3_W,  32'h10, 32'hDEAD55EF, 32'h0, 1'b0, "sw_10_restore");
`endif
    drain("misalign");
  endtask

  task automatic test_errors;
    issue(1'b1, F3_W, 32'h000, 32'h0A0B0C0D, 32'h0, 1'b0, "sw_first_word");
    issue(1'b1, F3_W, 32'h3FC, 32'h11223344, 32'h0, 1'b0, "sw_last_word");
    issue(1'b1, F3_W, 32'h400, 32'hFFFFFFFF, 32'h0, 1'b1, "sw_oor");
    issue(1'b1, F3_B, 32'h401, 32'hFFFFFFFF, 32'h0, 1'b1, "sb_oor");
    issue(1'b0, F3_W, 32'h400, 32'h0, 32'h0, 1'b1, "lw_oor");
    issue(1'b0, F3_W, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, "lw_top_oor");
    issue(1'b0, 3'b011, 32'h000, 32'h0, 32'h0, 1'b1, "load_f3_011");
    issue(1'b0, 3'b110, 32'h000, 32'h0, 32'h0, 1'b1, "load_f3_110");
    issue(1'b0, 3'b111, 32'h000, 32'h0, 32'h0, 1'b1, "load_f3_111");
    issue(1'b1, 3'b011, 32'h000, 32'hFFFFFFFF, 32'h0, 1'b1, "store_f3_011");
    issue(1'b1, 3'b100, 32'h000, 32'hFFFFFFFF, 32'h0, 1'b1, "store_f3_100");
    issue(1'b1, 3'b101, 32'h3FC, 32'hFFFFFFFF, 32'h0, 1'b1, "store_f3_101");
    issue(1'b0, F3_W, 32'h000, 32'h0, 32'h0A0B0C0D, 1'b0, "lw_first_unchanged");
    issue(1'b0, F3_W, 32'h3FC, 32'h0, 32'h11223344, 1'b0, "lw_last_unchanged");
    drain("errors");
  endtask

  task automatic test_back_to_back;
    logic [2:0]  ld_f3 [5];
    logic [2:0]  st_f3 [3];
    logic [2:0]  f3;
    logic [1:0]  lane;
    logic [31:0] d;
    logic        we;
    int          w;
    int          n_ops;
    time         t0;
    ld_f3[0] = F3_B; ld_f3[1] = F3_H; ld_f3[2] = F3_W; ld_f3[3] = F3_BU; ld_f3[4] = F3_HU;
    st_f3[0] = F3_B; st_f3[1] = F3_H; st_f3[2] = F3_W;
    n_ops = 0;
    t0 = $time;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      model_mem[i] = d;
      issue(1'b1, F3_W, 32'h100 + 32'(i * 4), d, 32'h0, 1'b0, "b2b_init");
      n_ops++;
    end
    for (int i = 0; i < 40; i++) begin
      w  = int'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      f3 = we ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
      lane = 2'($urandom_range(0, 3));
      if (f3 == F3_H || f3 == F3_HU) lane[0] = 1'b0;
      if (f3 == F3_W) lane = 2'b00;
      d = $urandom;
      if (we) begin
        model_mem[w] = model_store(model_mem[w], f3, lane, d);
        issue(1'b1, f3, 32'h100 + 32'(w * 4) + {30'h0, lane}, d, 32'h0, 1'b0, "b2b_store");
      end else begin
        issue(1'b0, f3, 32'h100 + 32'(w * 4) + {30'h0, lane}, 32'h0,
              model_load(model_mem[w], f3, lane), 1'b0, "b2b_load");
      end
      n_ops++;
    end
    tests_run++;
    if (($time - t0) != time'(n_ops * 10)) begin
      tests_failed++;
      $display("FAIL b2b_throughput: got %0t time units for %0d requests, required %0d",
               $time - t0, n_ops, n_ops * 10);
    end
    drain("back_to_back");
  endtask

  task automatic test_stall;
    RSP_READY = 1'b0;
    issue(1'b0, F3_W, 32'h3FC, 32'h0, 32'h11223344, 1'b0, "stall_first");
    REQ_VALID  = 1'b1;
    REQ_WE     = 1'b0;
    REQ_FUNCT3 = F3_W;
    REQ_ADDR   = 32'h0;
    for (int c = 0; c < 3; c++) begin
      #0;
      tests_run++;
      if (REQ_READY !== 1'b0) begin tests_failed++; $display("FAIL stall_req_ready: cycle %0d got %b, required 0", c, REQ_READY); end
      tests_run++;
      if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'h11223344 || RSP_ERR !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold: cycle %0d got valid=%b rdata=%h err=%b, required valid=1 rdata=11223344 err=0",
                 c, RSP_VALID, RSP_RDATA, RSP_ERR);
      end
      @(posedge CLK);
      #1;
    end
    RSP_READY = 1'b1;
    #1;
    tests_run++;
    if (REQ_READY !== 1'b1) begin tests_failed++; $display("FAIL stall_release_ready: got %b, required 1", REQ_READY); end
    exp_q.push_back('{32'h0A0B0C0D, 1'b0, "stall_second"});
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    tests_run++;
    if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'h0A0B0C0D) begin
      tests_failed++;
      $display("FAIL stall_release_accept: got valid=%b rdata=%h, required valid=1 rdata=0a0b0c0d",
               RSP_VALID, RSP_RDATA);
    end
    drain("stall");
  endtask

  task automatic test_reset_mid_hold;
    RSP_READY = 1'b0;
    issue(1'b0, F3_W, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, "pre_reset_dropped");
    REQ_VALID  = 1'b1;
    REQ_WE     = 1'b1;
    REQ_FUNCT3 = F3_W;
    REQ_ADDR   = 32'h10;
    REQ_WDATA  = 32'h12345678;
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    tests_run++;
    if (RSP_VALID !== 1'b0 || RSP_RDATA !== 32'h0 || RSP_ERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_hold: got valid=%b rdata=%h err=%b, required all 0", RSP_VALID, RSP_RDATA, RSP_ERR);
    end
    exp_q.delete();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    REQ_VALID = 1'b0;
    RSP_READY = 1'b1;
    tests_run++;
    if (RSP_VALID !== 1'b0) begin tests_failed++; $display("FAIL reset_no_accept: got valid=%b, required 0", RSP_VALID); end
    issue(1'b0, F3_W, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, "lw_10_after_reset");
    issue(1'b0, F3_W, 32'h000, 32'h0, 32'h0A0B0C0D, 1'b0, "lw_0_after_reset");
    drain("reset_mid_hold");
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_extend();
    test_byte_store();
    test_misalign();
    test_errors();
    test_back_to_back();
    test_stall();
    test_reset_mid_hold();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL final_queue: got %0d outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
